// File: rtl/jelly_data_serializer_keep.sv
// Lane serializer: emits only the kept lanes of each NUM*DATA_WIDTH word, one lane per clock.
// Optional output skid register enabled by JELLY_DATA_SERIALIZER_KEEP_SKID_EN.
module jelly_data_serializer_keep #(
  parameter int NUM        = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cke,
  input  logic                      endian,
  input  logic [NUM*DATA_WIDTH-1:0] s_data,
  input  logic [NUM-1:0]            s_keep,
  input  logic                      s_last,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [DATA_WIDTH-1:0]     m_data,
  output logic                      m_last,
  output logic                      m_valid,
  input  logic                      m_ready
);

  logic [NUM*DATA_WIDTH-1:0] r_buf_data;
  logic [NUM-1:0]            r_buf_keep;
  logic                      r_buf_last;

  logic [NUM-1:0]            w_sel;
  logic [DATA_WIDTH-1:0]     w_cur_data;
  logic                      w_onehot;
  logic                      w_core_valid;
  logic                      w_core_last;
  logic                      w_core_ready;
  logic                      w_core_take;
  logic                      w_s_accept;

  // Current lane: lowest remaining lane for endian=0, highest for endian=1.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    logic found;
    w_sel = '0;
    found = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      if (!endian) begin
        if (r_buf_keep[i] && !found) begin
          w_sel[i] = 1'b1;
          found    = 1'b1;
        end
      end else begin
        if (r_buf_keep[NUM-1-i] && !found) begin
          w_sel[NUM-1-i] = 1'b1;
          found          = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_cur_data = '0;
    for (int i = 0; i < NUM; i++) begin
      if (w_sel[i]) begin
        w_cur_data = r_buf_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_onehot     = (r_buf_keep != '0) && ((r_buf_keep & (r_buf_keep - NUM'(1))) == '0);
  assign w_core_valid = |r_buf_keep;
  assign w_core_last  = r_buf_last & w_onehot;
  assign w_core_take  = w_core_valid & w_core_ready & cke;

  // A new word may load while the final lane of the current one leaves.
  assign s_ready    = cke & (~w_core_valid | (w_onehot & w_core_ready));
  assign w_s_accept = s_valid & s_ready;

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_data <= '0;
      r_buf_keep <= '0;
      r_buf_last <= 1'b0;
    end else if (cke) begin
      if (w_s_accept) begin
        r_buf_data <= s_data;
        r_buf_keep <= s_keep;
        r_buf_last <= s_last & (|s_keep);
      end else if (w_core_take) begin
        r_buf_keep <= r_buf_keep & ~w_sel;
      end
    end
  end

`ifdef JELLY_DATA_SERIALIZER_KEEP_SKID_EN
  logic [DATA_WIDTH-1:0] r_sk_data [2];
  logic [1:0]            r_sk_last;
  logic [1:0]            r_sk_cnt;
  logic                  w_pop;

  // Readiness depends only on skid occupancy, breaking the m_ready -> s_ready path.
  assign w_core_ready = (r_sk_cnt != 2'd2);
  assign w_pop        = (r_sk_cnt != 2'd0) & m_ready & cke;

  // NOTE: the skid entries are reset (not just the count) so m_data reads 0 whenever empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sk_data[0] <= '0;
      r_sk_data[1] <= '0;
      r_sk_last    <= '0;
      r_sk_cnt     <= '0;
    end else if (cke) begin
      case ({w_core_take, w_pop})
        2'b10: begin
          if (r_sk_cnt == 2'd0) begin
            r_sk_data[0] <= w_cur_data;
            r_sk_last[0] <= w_core_last;
          end else begin
            r_sk_data[1] <= w_cur_data;
            r_sk_last[1] <= w_core_last;
          end
          r_sk_cnt <= r_sk_cnt + 2'd1;
        end
        2'b01: begin
          r_sk_data[0] <= r_sk_data[1];
          r_sk_last[0] <= r_sk_last[1];
          r_sk_data[1] <= '0;
          r_sk_last[1] <= 1'b0;
          r_sk_cnt     <= r_sk_cnt - 2'd1;
        end
        2'b11: begin
          // Push and pop together only happen with exactly one entry held.
          r_sk_data[0] <= w_cur_data;
          r_sk_last[0] <= w_core_last;
        end
        default: ;
      endcase
    end
  end

  assign m_data  = r_sk_data[0];
  assign m_last  = r_sk_last[0];
  assign m_valid = (r_sk_cnt != 2'd0);
`else
  assign w_core_ready = m_ready;
  assign m_data       = w_cur_data;
  assign m_last       = w_core_last;
  assign m_valid      = w_core_valid;
`endif

endmodule

// File: tb/tb_jelly_data_serializer_keep.sv
// Bench for jelly_data_serializer_keep: lane-queue model plus per-cycle output compare,
// with literal cycle traces for the directed cases.
module tb_jelly_data_serializer_keep;

  localparam int NUM = 4;
  localparam int DW  = 8;
`ifdef JELLY_DATA_SERIALIZER_KEEP_SKID_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic            clk = 1'b0;
  logic            reset, cke, endian;
  logic [NUM*DW-1:0] s_data;
  logic [NUM-1:0]  s_keep;
  logic            s_last, s_valid, s_ready;
  logic [DW-1:0]   m_data;
  logic            m_last, m_valid, m_ready;
  logic            rand_ready = 1'b0;

  jelly_data_serializer_keep #(.NUM(NUM), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .reset   (reset),
    .cke     (cke),
    .endian  (endian),
    .s_data  (s_data),
    .s_keep  (s_keep),
    .s_last  (s_last),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Model: each accepted word becomes the ordered list of its kept lanes.
  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } lane_t;
  lane_t sbq[$];

  function automatic void model_word(input logic [NUM*DW-1:0] d, input logic [NUM-1:0] k,
                                     input logic l, input logic e);
    int    idx[$];
    int    p;
    lane_t t;
    for (int i = 0; i < NUM; i++) begin
      p = e ? (NUM - 1 - i) : i;
      if (k[p]) idx.push_back(p);
    end
    for (int j = 0; j < idx.size(); j++) begin
      t.d = d[idx[j]*DW +: DW];
      t.l = l && (j == idx.size() - 1);
      sbq.push_back(t);
    end
  endfunction

  // Output compare, every cycle, away from the active edge.
  int            hs_lanes = 0;
  int            hs_lasts = 0;
  logic          hold;
  logic [DW-1:0] hold_d;
  logic          hold_l;
  lane_t         e_lane;

  initial begin
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sbq.delete();
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", m_valid, 1);
          check("hold_data", m_data, hold_d);
          check("hold_last", m_last, hold_l);
        end
        hold = 1'b0;
        if (m_valid) begin
          if (!(m_ready && cke)) begin
            hold   = 1'b1;
            hold_d = m_data;
            hold_l = m_last;
          end else if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_lane: got data %h last %0d, model queue empty", m_data, m_last);
          end else begin
            e_lane = sbq.pop_front();
            check("lane_data", m_data, e_lane.d);
            check("lane_last", m_last, e_lane.l);
            hs_lanes++;
            if (m_last) hs_lasts++;
          end
        end
      end
    end
  end

  // Sink readiness: random when enabled, otherwise always ready.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send(input logic [NUM*DW-1:0] d, input logic [NUM-1:0] k, input logic l);
    bit done;
    done    = 1'b0;
    s_data  = d;
    s_keep  = k;
    s_last  = l;
    s_valid = 1'b1;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (s_ready && cke) begin
        model_word(d, k, l, endian);
        done = 1'b1;
      end
    end
    if (!done) timeout("send_accept");
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !m_valid) done = 1'b1;
    end
    if (!done) timeout("drain");
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] tr_d [16];
  logic          tr_v [16];
  logic          tr_l [16];

  task automatic trace(input int n);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      tr_v[i] = m_valid;
      tr_d[i] = m_data;
      tr_l[i] = m_last;
    end
  endtask

  task automatic wait_lane(input logic [DW-1:0] v, output bit found);
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (m_valid && m_data == v) found = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  h_lanes, h_lasts;
    bit  found;
    logic [7:0] b;

    reset = 1'b1; cke = 1'b1; endian = 1'b0;
    s_data = '0; s_keep = '0; s_last = 1'b0; s_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_m_valid", m_valid, 0);
    check("reset_m_last", m_last, 0);
    check("reset_m_data", m_data, 0);
    check("reset_s_ready", s_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Full keep, two words back to back: 8 lanes with no bubble.
    fork
      begin
        send(32'h44332211, 4'hF, 1'b1);
        send(32'h88776655, 4'hF, 1'b1);
      end
      trace(LAT + 9);
    join
    for (int i = 1; i <= LAT; i++) check("full_pre_valid", tr_v[i], 0);
    for (int j = 0; j < 8; j++) begin
      check("full_valid", tr_v[LAT+1+j], 1);
      check("full_data", tr_d[LAT+1+j], (j + 1) * 17);
      check("full_last", tr_l[LAT+1+j], (j == 3 || j == 7) ? 1 : 0);
    end
    check("full_post_valid", tr_v[LAT+9], 0);
    drain();

    // Sparse keep, MSB lane first.
    endian = 1'b1;
    fork
      send(32'hDDCCBBAA, 4'b1010, 1'b1);
      trace(LAT + 3);
    join
    check("sparse_v0", tr_v[LAT+1], 1);
    check("sparse_d0", tr_d[LAT+1], 8'hDD);
    check("sparse_l0", tr_l[LAT+1], 0);
    check("sparse_v1", tr_v[LAT+2], 1);
    check("sparse_d1", tr_d[LAT+2], 8'hBB);
    check("sparse_l1", tr_l[LAT+2], 1);
    check("sparse_post_valid", tr_v[LAT+3], 0);
    drain();
    endian = 1'b0;

    // Empty-keep word with last between two full words.
    h_lanes = hs_lanes;
    h_lasts = hs_lasts;
    send(32'h13121110, 4'hF, 1'b0);
    send(32'hFFFFFFFF, 4'h0, 1'b1);
    send(32'h17161514, 4'hF, 1'b1);
    drain();
    check("drop_lane_count", hs_lanes - h_lanes, 8);
    check("drop_last_count", hs_lasts - h_lasts, 1);

    // Clock enable low for 5 cycles after two lanes.
    fork
      send(32'hA4A3A2A1, 4'hF, 1'b1);
      begin
        wait_lane(8'hA2, found);
        if (!found) timeout("cke_wait_A2");
        @(posedge clk);
        #1;
        cke = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("cke_m_valid", m_valid, 1);
          check("cke_m_data", m_data, 8'hA3);
          check("cke_s_ready", s_ready, 0);
        end
        @(posedge clk);
        #1;
        cke = 1'b1;
      end
    join
    drain();

    // Reset after two of four lanes.
    fork
      send(32'hD4D3D2D1, 4'hF, 1'b1);
      begin
        wait_lane(8'hD2, found);
        if (!found) timeout("rst_wait_D2");
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_m_valid", m_valid, 0);
        check("rst_mid_m_data", m_data, 0);
        check("rst_mid_m_last", m_last, 0);
        check("rst_mid_s_ready", s_ready, 1);
      end
    join
    @(posedge clk);
    #1;
    fork
      send(32'hE4E3E2E1, 4'hF, 1'b1);
      begin
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
          @(negedge clk);
          if (m_valid) found = 1'b1;
        end
        if (!found) timeout("rst_post_wait");
        else check("rst_post_first", m_data, 8'hE1);
      end
    join
    drain();

    // Random sink stalls, random keep/last/gaps, incrementing lane bytes.
    rand_ready = 1'b1;
    b = 8'h00;
    for (int pass = 0; pass < 2; pass++) begin
      endian = 1'(pass);
      for (int w = 0; w < 20; w++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        send({b + 8'd3, b + 8'd2, b + 8'd1, b}, 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)));
        b = b + 8'd4;
      end
      drain();
    end
    rand_ready = 1'b0;
    endian = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
